muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (dR1/dR2 values) plus funct3 and rd.
- Produces a write-back triple (regw_out, rd_out, result) that drives the register-file write port (regw, waddr, wdata).
- Holds the pipeline via busy while an operation iterates.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_signfix.sv | 15 +
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and opcode classification helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/write-back bundle between the issue stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int n = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [n-1:0] opa;
  logic [n-1:0] opb;
  logic [4:0]   rd;
  logic         flush;
  logic         busy;
  logic         done;
  logic [n-1:0] result;
  logic [4:0]   rd_out;
  logic         regw_out;

  modport master (
    output start, funct3, opa, opb, rd, flush,
    input  busy, done, result, rd_out, regw_out
  );

  modport slave (
    input  start, funct3, opa, opb, rd, flush,
    output busy, done, result, rd_out, regw_out
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Two-channel conditional two's-complement: magnitudes on the way in, sign restore on the way out.
module muldiv_signfix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a,
  input  logic          neg_a,
  input  logic [WB-1:0] b,
  input  logic          neg_b,
  output logic [WA-1:0] a_out,
  output logic [WB-1:0] b_out
);
  assign a_out = neg_a ? -a : a;
  assign b_out = neg_b ? -b : b;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Build option MULDIV_FAST_MUL_EN: multiplies use a one-cycle combinational product.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int n = 32
) (
  input  logic    clock,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int            CW   = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  state_e         state;
  logic [CW-1:0]  cnt;
  logic           busy_q, done_q, regw_q;
  logic [n-1:0]   result_q;
  logic [4:0]     rd_q;

  logic [2:0]     f_r;
  logic [n-1:0]   opa_m, opb_m, hi, lo, hi_nx, lo_nx;
  logic           neg_q_r, neg_r_r;

  logic           sa, sb, acc_div, div_zero, ovf, fix_path;
  logic [n-1:0]   mag_a, mag_b;
  logic [n:0]     sum, shifted;
  logic [n-1:0]   diff;
  logic           ge;
  logic [2*n-1:0] res_a;
  logic [n-1:0]   res_b, res_sel;

  assign acc_div  = is_div(bus.funct3);
  assign sa       = is_signed_a(bus.funct3) & bus.opa[n-1];
  assign sb       = is_signed_b(bus.funct3) & bus.opb[n-1];
  assign div_zero = (bus.opb == '0);
  assign ovf      = acc_div && is_signed_b(bus.funct3) &&
                    (bus.opa == {1'b1, {(n-1){1'b0}}}) && (bus.opb == '1);
  assign fix_path = acc_div ? (div_zero || ovf) : FAST_MUL;

  muldiv_signfix #(.WA(n), .WB(n)) u_opfix (
    .a(bus.opa), .neg_a(sa), .b(bus.opb), .neg_b(sb),
    .a_out(mag_a), .b_out(mag_b)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*n-1:0] prod;
  assign prod = {{n{1'b0}}, opa_m} * {{n{1'b0}}, lo};
`endif

  // hi/lo double as product accumulator (multiply) and remainder/quotient (divide)
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opa_m} : '0);
    shifted = {hi, lo[n-1]};
    ge      = shifted >= {1'b0, opb_m};
    diff    = shifted[n-1:0] - opb_m;
    hi_nx   = hi;
    lo_nx   = lo;
    if (state == S_CALC) begin
      if (is_div(f_r)) begin
        hi_nx = ge ? diff : shifted[n-1:0];
        lo_nx = {lo[n-2:0], ge};
      end else begin
        hi_nx = sum[n:1];
        lo_nx = {sum[0], lo[n-1:1]};
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (state == S_FIX && !is_div(f_r)) begin
      hi_nx = prod[2*n-1:n];
      lo_nx = prod[n-1:0];
    end
`endif
  end

  muldiv_signfix #(.WA(2*n), .WB(n)) u_resfix (
    .a(is_div(f_r) ? {{n{1'b0}}, lo_nx} : {hi_nx, lo_nx}), .neg_a(neg_q_r),
    .b(hi_nx), .neg_b(neg_r_r),
    .a_out(res_a), .b_out(res_b)
  );

  always_comb begin
    res_sel = res_a[n-1:0];
    case (f_r)
      F_MULH, F_MULHSU, F_MULHU: res_sel = res_a[2*n-1:n];
      F_REM, F_REMU:             res_sel = res_b;
      default: ;
    endcase
  end

  // Special cases are pre-loaded so the normal sign-restore path yields their result.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && bus.start) begin
      f_r     <= bus.funct3;
      opa_m   <= mag_a;
      opb_m   <= mag_b;
      neg_r_r <= sa;
      if (acc_div && div_zero) begin
        hi      <= mag_a;
        lo      <= '1;
        neg_q_r <= 1'b0;
      end else begin
        hi      <= '0;
        lo      <= acc_div ? mag_a : mag_b;
        neg_q_r <= sa ^ sb;
      end
    end else begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      regw_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      regw_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state  <= fix_path ? S_FIX : S_CALC;
          cnt    <= '0;
          busy_q <= 1'b1;
          rd_q   <= bus.rd;
        end
        S_CALC: if (bus.flush) begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            regw_q   <= (rd_q != '0);
            result_q <= res_sel;
          end
        end
        S_FIX: if (bus.flush) begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end else begin
          state    <= S_DONE;
          done_q   <= 1'b1;
          regw_q   <= (rd_q != '0);
          result_q <= res_sel;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.regw_out = regw_q;
  assign bus.result   = result_q;
  assign bus.rd_out   = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus randomized traffic against a cycle-level reference.
module tb_muldiv_unit;
  localparam int N = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = N + 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  muldiv_if #(.n(N)) bus ();
  muldiv_unit #(.n(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Reference: results from plain integer arithmetic, timing as cycles since acceptance.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa64, sb64;
    logic [63:0] p, ua, ub;
    int          ia, ib;
    sa64 = longint'(signed'(a));
    sb64 = longint'(signed'(b));
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    ia   = a;
    ib   = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 2;
      return N + 1;
    end
    return MLAT;
  endfunction

  int          mk = 0;
  int          mL = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mk <= 0; mL <= 0; m_res <= '0; m_pend <= '0; m_rd <= '0;
    end else if (mk == 0) begin
      if (bus.start) begin
        mk     <= 1;
        mL     <= lat_of(bus.funct3, bus.opa, bus.opb);
        m_rd   <= bus.rd;
        m_pend <= ref_result(bus.funct3, bus.opa, bus.opb);
      end
    end else if (mk < mL) begin
      if (bus.flush) mk <= 0;
      else begin
        mk <= mk + 1;
        if (mk + 1 == mL) m_res <= m_pend;
      end
    end else begin
      mk <= 0;
    end
  end

  function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    bus.funct3 = f; bus.opa = a; bus.opb = b; bus.rd = r; bus.start = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input int lat);
    int w;
    @(negedge clock);
    drive(f, a, b, r);
    @(negedge clock);
    bus.start = 1'b0;
    w = 1;
    while (!bus.done && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk(bus.done === 1'b1, {nm, "_timeout"}, 64'(bus.done), 64'(1));
    chk(bus.result === exp, nm, 64'(bus.result), 64'(exp));
    chk(w == lat, {nm, "_lat"}, 64'(w), 64'(lat));
    chk(bus.regw_out === (r != 0) && bus.rd_out === r, {nm, "_wb"},
        64'({bus.regw_out, bus.rd_out}), 64'({(r != 0), r}));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [7:0]  ctl_act, ctl_exp;
  logic [31:0] rsave;
  int          ndone;
  bit          ed;

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.opa = '0; bus.opb = '0; bus.rd = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk({bus.busy, bus.done, bus.regw_out, bus.rd_out, bus.result} === '0, "reset_state",
        64'({bus.busy, bus.done, bus.regw_out, bus.rd_out}), 64'(0));
    reset = 1'b0;

    fork
      begin
        while (!stim_done) begin
          @(negedge clock);
          ed      = (mk != 0) && (mk == mL);
          ctl_act = {bus.busy, bus.done, bus.regw_out, bus.rd_out};
          ctl_exp = {(mk != 0), ed, ed && (m_rd != 0), m_rd};
          chk(ctl_act === ctl_exp, "ctl", 64'(ctl_act), 64'(ctl_exp));
          chk(bus.result === m_res, "result", 64'(bus.result), 64'(m_res));
        end
      end
      begin
        run_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MLAT);
        run_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, MLAT);
        run_op("mulh",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, MLAT);
        run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, MLAT);
        run_op("div",      3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, N + 1);
        run_op("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, N + 1);
        run_op("divu",     3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       N + 1);
        run_op("remu",     3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        N + 1);
        run_op("divu_z",   3'd5, 32'h1234,     32'd0,        5'd13, 32'hFFFFFFFF, 2);
        run_op("rem_z",    3'd6, 32'h1234,     32'd0,        5'd14, 32'h1234,     2);
        run_op("div_negz", 3'd4, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF, 2);
        run_op("rem_negz", 3'd6, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9, 2);
        run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 2);
        run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h0,        2);
        run_op("rd0",      3'd5, 32'd81,       32'd9,        5'd0,  32'd9,        N + 1);

        @(negedge clock);
        drive(3'd5, 32'd1000, 32'd7, 5'd3);
        @(negedge clock); bus.start = 1'b0;
        repeat (4) @(negedge clock);
        drive(3'd0, 32'd5, 32'd5, 5'd9);
        @(negedge clock); bus.start = 1'b0;
        ndone = 0; rsave = '0;
        for (int i = 0; i < 60; i++) begin
          if (bus.done) begin ndone++; rsave = bus.result; end
          @(negedge clock);
        end
        chk(ndone == 1, "ign_start_dones", 64'(ndone), 64'(1));
        chk(rsave == 32'd142, "ign_start_result", 64'(rsave), 64'(142));
        chk(bus.rd_out == 5'd3, "ign_start_rd", 64'(bus.rd_out), 64'(3));

        drive(3'd5, 32'd5000, 32'd3, 5'd21);
        @(negedge clock); bus.start = 1'b0;
        repeat (10) @(negedge clock);
        bus.flush = 1'b1;
        @(negedge clock); bus.flush = 1'b0;
        chk(bus.busy == 1'b0, "flush_busy", 64'(bus.busy), 64'(0));
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
          if (bus.done) ndone++;
          @(negedge clock);
        end
        chk(ndone == 0, "flush_no_done", 64'(ndone), 64'(0));
        chk(bus.result == 32'd142, "flush_result_held", 64'(bus.result), 64'(142));

        drive(3'd5, 32'd5000, 32'd9, 5'd4);
        @(negedge clock); bus.start = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk({bus.busy, bus.done, bus.regw_out, bus.result} === '0, "reset_mid_calc",
               64'({bus.busy, bus.done, bus.result}), 64'(0));
        @(negedge clock); reset = 1'b0;
        run_op("after_reset", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd6, 32'hFFFFFFEB, MLAT);

        for (int c = 0; c < 3000; c++) begin
          @(negedge clock);
          bus.start  = ($urandom_range(0, 3) == 0);
          bus.funct3 = 3'($urandom_range(0, 7));
          bus.opa    = pick();
          bus.opb    = pick();
          bus.rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          bus.flush  = ($urandom_range(0, 149) == 0);
        end
        @(negedge clock);
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (40) @(negedge clock);
        stim_done = 1'b1;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
